// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational instruction memory and
// hands captured words to decode through a valid/ready IF/ID register.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [31:0] MEM_DEPTH  = 32'd65,
    parameter logic [31:0] HALT_INSTR = 32'h00000073,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic             if_valid,
    output logic [31:0]      if_instr,
    output logic [31:0]      if_pc,
    input  logic             id_ready,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [31:0]      pc_q,       pc_d;
    logic             if_valid_q, if_valid_d;
    logic [31:0]      if_instr_q, if_instr_d;
    logic [31:0]      if_pc_q,    if_pc_d;
    logic             halted_q,   halted_d;
    logic             fault_q,    fault_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             acc;

    // The IF/ID slot can take a new word when it is empty or being drained.
    assign acc = !if_valid_q || id_ready;

    // NOTE: every next-state signal gets its hold value first so no path through
    // the case statement leaves one unassigned (which would infer a latch).
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        halted_d   = halted_q;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_d       = redirect_target;
                    if_valid_d = 1'b0;
                end else if (pc_q >= MEM_DEPTH) begin
                    fault_d  = 1'b1;
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                    if (acc) if_valid_d = 1'b0;
                end else if (acc) begin
                    if_instr_d = imem_data;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                    // A halting word is still delivered; the PC parks on it.
                    if (imem_data == HALT_INSTR) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        pc_d = pc_q + 32'd1;
                    end
                end
            end
            ST_HALT: begin
                if (id_ready) if_valid_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= 32'd0;
            if_pc_q    <= 32'd0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a behavioural memory array feeds
// imem_data; inputs change and outputs are sampled on the falling edge.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halted;
    logic        fault;
    logic [15:0] fetch_count;

    logic [31:0] mem [0:127];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 32'd128) ? mem[imem_addr[6:0]] : 32'h0;

    instruction_fetch_unit dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .id_ready        (id_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halted          (halted),
        .fault           (fault),
        .fetch_count     (fetch_count)
    );

    task automatic load_mem();
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 | i;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44; mem[4] = 32'h55;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start = 1'b0; id_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'd0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Pulse start; on return the DUT is in RUN and has not yet captured.
    task automatic kick(input logic rdy);
        start = 1'b1; id_ready = rdy;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        load_mem();
        do_reset();
        n_cmp++;
        if ({imem_addr, if_valid, if_instr, if_pc, halted, fault, fetch_count} !== {32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 16'd0}) begin
            n_err++;
            $display("FAIL reset_values: addr=%0h v=%b instr=%0h pc=%0h h=%b f=%b cnt=%0d, required all zero",
                     imem_addr, if_valid, if_instr, if_pc, halted, fault, fetch_count);
        end
        // IDLE ignores redirects and never captures.
        redirect_valid = 1'b1; redirect_target = 32'd5; id_ready = 1'b1;
        repeat (2) @(negedge clk);
        redirect_valid = 1'b0;
        n_cmp++;
        if ({imem_addr, if_valid, fetch_count} !== {32'd0, 1'b0, 16'd0}) begin
            n_err++;
            $display("FAIL idle_hold: addr=%0h v=%b cnt=%0d, required addr=0 v=0 cnt=0", imem_addr, if_valid, fetch_count);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_w [0:4];
        exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33; exp_w[3] = 32'h44; exp_w[4] = 32'h55;
        load_mem();
        do_reset();
        kick(1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({if_valid, if_instr, if_pc, fetch_count} !== {1'b1, exp_w[i], 32'(i), 16'(i + 1)}) begin
                n_err++;
                $display("FAIL seq_fetch[%0d]: v=%b instr=%0h pc=%0d cnt=%0d, required v=1 instr=%0h pc=%0d cnt=%0d",
                         i, if_valid, if_instr, if_pc, fetch_count, exp_w[i], i, i + 1);
            end
        end
    endtask

    task automatic test_stall();
        load_mem();
        do_reset();
        kick(1'b1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({if_pc, imem_addr} !== {32'd2, 32'd3}) begin
            n_err++;
            $display("FAIL stall_setup: if_pc=%0d pc=%0d, required 2/3", if_pc, imem_addr);
        end
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({if_valid, if_instr, if_pc, imem_addr, fetch_count} !== {1'b1, 32'h33, 32'd2, 32'd3, 16'd3}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: v=%b instr=%0h if_pc=%0d pc=%0d cnt=%0d, required 1/33/2/3/3",
                         i, if_valid, if_instr, if_pc, imem_addr, fetch_count);
            end
        end
        id_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({if_instr, if_pc, fetch_count} !== {32'h44, 32'd3, 16'd4}) begin
            n_err++;
            $display("FAIL stall_resume: instr=%0h if_pc=%0d cnt=%0d, required 44/3/4", if_instr, if_pc, fetch_count);
        end
        @(negedge clk);
        n_cmp++;
        if ({if_instr, if_pc} !== {32'h55, 32'd4}) begin
            n_err++;
            $display("FAIL stall_next: instr=%0h if_pc=%0d, required 55/4", if_instr, if_pc);
        end
    endtask

    task automatic test_redirect();
        load_mem();
        mem[10] = 32'hAA; mem[20] = 32'hBB;
        do_reset();
        kick(1'b1);
        repeat (3) @(negedge clk);
        id_ready = 1'b0;
        @(negedge clk);
        // Redirect while decode is stalled: the held entry is flushed.
        redirect_valid = 1'b1; redirect_target = 32'd10;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_cmp++;
        if ({if_valid, imem_addr, fetch_count} !== {1'b0, 32'd10, 16'd3}) begin
            n_err++;
            $display("FAIL redir_flush: v=%b pc=%0d cnt=%0d, required 0/10/3", if_valid, imem_addr, fetch_count);
        end
        @(negedge clk);
        n_cmp++;
        if ({if_valid, if_instr, if_pc, fetch_count} !== {1'b1, 32'hAA, 32'd10, 16'd4}) begin
            n_err++;
            $display("FAIL redir_capture: v=%b instr=%0h if_pc=%0d cnt=%0d, required 1/aa/10/4",
                     if_valid, if_instr, if_pc, fetch_count);
        end
        // Redirect together with id_ready: entry is dropped, nothing captured.
        id_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'd20;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_cmp++;
        if ({if_valid, imem_addr, fetch_count} !== {1'b0, 32'd20, 16'd4}) begin
            n_err++;
            $display("FAIL redir_ready: v=%b pc=%0d cnt=%0d, required 0/20/4", if_valid, imem_addr, fetch_count);
        end
        @(negedge clk);
        n_cmp++;
        if ({if_instr, if_pc, imem_addr} !== {32'hBB, 32'd20, 32'd21}) begin
            n_err++;
            $display("FAIL redir_ready_capture: instr=%0h if_pc=%0d pc=%0d, required bb/20/21", if_instr, if_pc, imem_addr);
        end
    endtask

    task automatic test_halt();
        load_mem();
        mem[3] = 32'h00000073;
        do_reset();
        kick(1'b1);
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({if_valid, if_instr, if_pc, halted, imem_addr, fetch_count} !== {1'b1, 32'h73, 32'd3, 1'b1, 32'd3, 16'd4}) begin
            n_err++;
            $display("FAIL halt_capture: v=%b instr=%0h if_pc=%0d h=%b pc=%0d cnt=%0d, required 1/73/3/1/3/4",
                     if_valid, if_instr, if_pc, halted, imem_addr, fetch_count);
        end
        @(negedge clk);
        n_cmp++;
        if ({if_valid, imem_addr, fetch_count} !== {1'b0, 32'd3, 16'd4}) begin
            n_err++;
            $display("FAIL halt_drain: v=%b pc=%0d cnt=%0d, required 0/3/4", if_valid, imem_addr, fetch_count);
        end
        redirect_valid = 1'b1; redirect_target = 32'd0; start = 1'b1;
        repeat (2) @(negedge clk);
        redirect_valid = 1'b0; start = 1'b0;
        n_cmp++;
        if ({if_valid, halted, fault, imem_addr, fetch_count} !== {1'b0, 1'b1, 1'b0, 32'd3, 16'd4}) begin
            n_err++;
            $display("FAIL halt_ignore: v=%b h=%b f=%b pc=%0d cnt=%0d, required 0/1/0/3/4",
                     if_valid, halted, fault, imem_addr, fetch_count);
        end
    endtask

    task automatic test_fault();
        // Last valid word (64) is fetched; PC 65 then faults.
        load_mem();
        mem[64] = 32'h64;
        do_reset();
        kick(1'b1);
        redirect_valid = 1'b1; redirect_target = 32'd64;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({if_valid, if_instr, if_pc, fault, imem_addr} !== {1'b1, 32'h64, 32'd64, 1'b0, 32'd65}) begin
            n_err++;
            $display("FAIL fault_boundary: v=%b instr=%0h if_pc=%0d f=%b pc=%0d, required 1/64/64/0/65",
                     if_valid, if_instr, if_pc, fault, imem_addr);
        end
        @(negedge clk);
        n_cmp++;
        if ({if_valid, fault, halted, imem_addr, fetch_count} !== {1'b0, 1'b1, 1'b1, 32'd65, 16'd1}) begin
            n_err++;
            $display("FAIL fault_at_depth: v=%b f=%b h=%b pc=%0d cnt=%0d, required 0/1/1/65/1",
                     if_valid, fault, halted, imem_addr, fetch_count);
        end
        // Redirect far out of range after one capture.
        do_reset();
        kick(1'b1);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_target = 32'd70;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_cmp++;
        if ({if_valid, fault, imem_addr} !== {1'b0, 1'b0, 32'd70}) begin
            n_err++;
            $display("FAIL fault_redirect: v=%b f=%b pc=%0d, required 0/0/70", if_valid, fault, imem_addr);
        end
        @(negedge clk);
        n_cmp++;
        if ({if_valid, fault, halted, fetch_count} !== {1'b0, 1'b1, 1'b1, 16'd1}) begin
            n_err++;
            $display("FAIL fault_70: v=%b f=%b h=%b cnt=%0d, required 0/1/1/1", if_valid, fault, halted, fetch_count);
        end
    endtask

    task automatic test_async_reset();
        load_mem();
        do_reset();
        kick(1'b1);
        repeat (7) @(negedge clk);
        n_cmp++;
        if ({if_valid, if_pc, imem_addr} !== {1'b1, 32'd6, 32'd7}) begin
            n_err++;
            $display("FAIL areset_setup: v=%b if_pc=%0d pc=%0d, required 1/6/7", if_valid, if_pc, imem_addr);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({imem_addr, if_valid, if_instr, if_pc, halted, fault, fetch_count} !== {32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 16'd0}) begin
            n_err++;
            $display("FAIL areset_immediate: addr=%0h v=%b instr=%0h pc=%0h h=%b f=%b cnt=%0d, required all zero",
                     imem_addr, if_valid, if_instr, if_pc, halted, fault, fetch_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({imem_addr, if_valid, fetch_count} !== {32'd0, 1'b0, 16'd0}) begin
            n_err++;
            $display("FAIL areset_idle: addr=%0h v=%b cnt=%0d, required 0/0/0", imem_addr, if_valid, fetch_count);
        end
        kick(1'b1);
        @(negedge clk);
        n_cmp++;
        if ({if_valid, if_instr, if_pc, fetch_count} !== {1'b1, 32'h11, 32'd0, 16'd1}) begin
            n_err++;
            $display("FAIL areset_restart: v=%b instr=%0h if_pc=%0d cnt=%0d, required 1/11/0/1",
                     if_valid, if_instr, if_pc, fetch_count);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_halt();
        test_fault();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage of the single-issue RISC-V core. Owns the program counter, drives the word address into the combinational instruction memory, and captures the returned word into an IF/ID pipeline register with a valid/ready handshake toward decode. It also handles redirects (branch/jump flush), halt on ECALL, out-of-range PC faults, and a fetched-instruction counter.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset (word address)
MEM_DEPTH, 65, number of valid instruction words; PC >= MEM_DEPTH is a fault
HALT_INSTR, 32'h00000073, encoding that halts fetch (ECALL)
CNT_W, 16, width of fetch_count

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; IDLE -> RUN
imem_addr  output  32  word address to instruction memory; always equals pc
imem_data  input  32  instruction word from memory, combinational from imem_addr
if_valid  output  1  IF/ID register holds a valid instruction
if_instr  output  32  IF/ID instruction
if_pc  output  32  word address of if_instr
id_ready  input  1  decode accepts IF/ID contents this cycle
redirect_valid  input  1  branch/jump taken; flush and reload PC
redirect_target  input  32  new PC (word address)
halted  output  1  fetch stopped (HALT state)
fault  output  1  sticky; PC went out of range
fetch_count  output  CNT_W  instructions captured since reset, saturating

Behaviour:
- Reset (async, reset_n=0): pc=RESET_PC, state=IDLE, if_valid=0, if_instr=0, if_pc=0, halted=0, fault=0, fetch_count=0. Takes effect immediately regardless of clk. Reset mid-operation discards all in-flight state.
- imem_addr = pc, combinational, in every state.
- States: IDLE, RUN, HALT. Encoding is free.
- IDLE: no capture, pc holds. start=1 -> RUN at next edge. redirect_valid ignored.
- RUN, accept condition: acc = !if_valid || id_ready.
- RUN, priority 1: redirect_valid=1 -> pc<=redirect_target, if_valid<=0 (flush, even if decode is stalled), no capture that cycle, fetch_count unchanged.
- RUN, priority 2: pc >= MEM_DEPTH (unsigned) -> fault<=1, state<=HALT, halted<=1, no capture, pc holds. If acc, if_valid<=0.
- RUN, priority 3: acc=1 -> if_instr<=imem_data, if_pc<=pc, if_valid<=1, pc<=pc+1 (32-bit wrap), fetch_count<=fetch_count+1 (saturates at all-ones).
- If the captured word == HALT_INSTR: it is still delivered to decode, but pc holds at its own address (no increment), state<=HALT, halted<=1.
- RUN, priority 4: acc=0 (decode stall) -> all registers hold; if_instr/if_pc stable while if_valid && !id_ready.
- Latency: an instruction at PC N appears on if_instr one edge after pc==N with acc=1. Sustained throughput is 1 instruction/cycle with id_ready=1.
- HALT: pc, fault, and fetch_count hold. redirect_valid and start ignored. A pending if_valid drains normally (id_ready=1 -> if_valid<=0). Only reset exits HALT.
- A redirect and id_ready in the same cycle: the redirect wins and the IF/ID entry is dropped, not handed off.
- start while in RUN or HALT: no effect.
- fault and halted remain set until reset.

Test Plan:
- Sequential fetch: memory words 0..4 = 0x11,0x22,0x33,0x44,0x55, start pulse, id_ready=1 -> if_instr 0x11..0x55 on consecutive cycles, if_pc 0..4, fetch_count=5 after 5 captures.
- Stall: id_ready=0 for 3 cycles while if_valid=1 with if_pc=2 -> if_instr/if_pc/pc held for 3 cycles; on id_ready=1 the next capture is PC 3, with no skip or duplicate.
- Redirect during stall: if_valid=1, id_ready=0, redirect_valid=1, target=10 -> next cycle if_valid=0, pc=10; the following cycle if_pc=10.
- Halt: word 3 = 0x00000073 -> captured with if_pc=3, halted=1 next cycle, pc stays 3, no further captures; a later redirect is ignored and fetch_count stops at 4.
- Fault: redirect_target=70 (MEM_DEPTH=65) -> next cycle fault=1, halted=1, if_valid=0, fetch_count unchanged.
- Async reset mid-run: drop reset_n between clock edges while pc=7, if_valid=1 -> outputs return to reset values immediately; after release, state is IDLE until start.
